pc_control_unit: RTL and testbench

//  Fetch/decode/sequencing stage of the single-cycle computer; sits directly upstream of the A/B registers.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/instr_decoder.sv | 34 +++
 rtl/pc_control_unit.sv | 114 +++++++++++
 tb/tb_pc_control_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the fetch/decode/sequencing stage:
//   instruction field widths, opcode values, FSM state encoding and the
//   decoded-control struct passed from instr_decoder to pc_control_unit.
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_W   = 4;
  localparam int IMM_W   = 4;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA  = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADDA = 4'h3;
  localparam logic [OPC_W-1:0] OP_ADDB = 4'h4;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h5;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h6;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } cpu_state_e;

  // Decoded control bits for one instruction, independent of FSM state.
  typedef struct packed {
    logic wen_a;    // instruction writes register A
    logic wen_b;    // instruction writes register B
    logic sel_alu;  // write data comes from the ALU instead of imm
    logic jmp;      // unconditional jump to imm
    logic jz;       // jump to imm when alu_zero is set
    logic hlt;      // stop execution
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder
//   Purely combinational opcode decode. Undefined opcodes decode to all
//   zeros, which behaves exactly like NOP.
// Ports
//   opcode  in   4  instruction opcode field (instr[7:4])
//   dec     out  -  decoded control struct (cpu_pkg::dec_t)
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output dec_t             dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_LDA:  dec.wen_a = 1'b1;
      OP_LDB:  dec.wen_b = 1'b1;
      OP_ADDA: begin
        dec.wen_a   = 1'b1;
        dec.sel_alu = 1'b1;
      end
      OP_ADDB: begin
        dec.wen_b   = 1'b1;
        dec.sel_alu = 1'b1;
      end
      OP_JMP:  dec.jmp = 1'b1;
      OP_JZ:   dec.jz  = 1'b1;
      OP_HLT:  dec.hlt = 1'b1;
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/pc_control_unit.sv
// pc_control_unit
//   Fetch/decode/sequencing stage of the single-cycle computer. Holds the
//   program counter that addresses the instruction ROM, decodes the current
//   instruction combinationally and drives write data plus per-register
//   write enables to the A/B register stage, which commits on the same clk
//   edge that advances pc. An IDLE/EXEC/HALT FSM gates execution and a
//   saturating counter tracks retired instructions.
// Ports
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   run       in   1   start request, sampled only in IDLE
//   instr     in   8   instruction at address pc ([7:4] opcode, [3:0] imm)
//   alu_res   in   W   ALU result, written back by ADDA/ADDB
//   alu_zero  in   1   ALU zero flag, condition for JZ
//   pc        out  AW  current instruction address
//   data      out  W   write data to register stage (0 when no enable)
//   wen_a     out  1   write enable, register A
//   wen_b     out  1   write enable, register B
//   halted    out  1   high while in HALT
//   icount    out  8   retired-instruction count, saturating at 255
//   state_dbg out  2   current FSM state, for observation only
// Handshake: run is a level request with no ready/acknowledge; it is
//   consumed on the first rising edge seen in IDLE and ignored otherwise.
module pc_control_unit
  import cpu_pkg::*;
#(
  parameter int W  = 4,
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  input  logic [W-1:0]       alu_res,
  input  logic               alu_zero,
  output logic [AW-1:0]      pc,
  output logic [W-1:0]       data,
  output logic               wen_a,
  output logic               wen_b,
  output logic               halted,
  output logic [7:0]         icount,
  output cpu_state_e         state_dbg
);

  cpu_state_e    state;
  cpu_state_e    state_nxt;
  dec_t          dec;
  logic          exec;
  logic [W-1:0]  imm;
  logic [AW-1:0] target;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_nxt;

  instr_decoder u_dec (
    .opcode (instr[INSTR_W-1 -: OPC_W]),
    .dec    (dec)
  );

  assign imm    = instr[W-1:0];
  assign target = AW'(imm);
  assign pc_inc = pc + AW'(1);  // natural wrap from 2**AW-1 to 0

  // State register, pc and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      icount <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (exec && (icount != 8'hFF)) begin
        icount <= icount + 8'd1;
      end
    end
  end

  // Next-state logic. HALT is only left through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (run)     state_nxt = ST_EXEC;
      ST_EXEC: if (dec.hlt) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and next pc. Every control output is qualified by EXEC, so
  // IDLE and HALT hold pc and never write.
  always_comb begin
    exec   = (state == ST_EXEC);
    halted = (state == ST_HALT);
    wen_a  = exec & dec.wen_a;
    wen_b  = exec & dec.wen_b;
    data   = '0;
    if (wen_a || wen_b) begin
      data = dec.sel_alu ? alu_res : imm;
    end
    pc_nxt = pc;
    if (exec) begin
      if (dec.hlt) begin
        pc_nxt = pc;  // park on the HLT address
      end else if (dec.jmp || (dec.jz && alu_zero)) begin
        pc_nxt = target;
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pc_control_unit.sv
module tb_pc_control_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [7:0] instr = 8'h00;
  logic [3:0] alu_res = 4'h0;
  logic       alu_zero = 1'b0;
  logic [3:0] pc;
  logic [3:0] data;
  logic       wen_a;
  logic       wen_b;
  logic       halted;
  logic [7:0] icount;
  cpu_state_e state_dbg;

  pc_control_unit #(.W(4), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .instr     (instr),
    .alu_res   (alu_res),
    .alu_zero  (alu_zero),
    .pc        (pc),
    .data      (data),
    .wen_a     (wen_a),
    .wen_b     (wen_b),
    .halted    (halted),
    .icount    (icount),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 running, 2 halted
  int   m_mode;
  int   m_pc;
  int   m_cnt;
  logic [7:0] rom [16];

  int n_checks = 0;
  int n_fail   = 0;
  int ever_both = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cpu_state_e mode_to_state(input int m);
    if (m == 1) return ST_EXEC;
    if (m == 2) return ST_HALT;
    return ST_IDLE;
  endfunction

  // Called just after a falling edge; leaves the bench just after the next one.
  task automatic cycle(input logic run_v, input logic az, input logic [3:0] ar);
    int op;
    int imm;
    int e_wa;
    int e_wb;
    int e_data;
    logic [7:0] ins;
    ins = rom[m_pc];
    instr = ins;
    run = run_v;
    alu_zero = az;
    alu_res = ar;
    op  = int'(ins) / 16;
    imm = int'(ins) % 16;
    e_wa = 0;
    e_wb = 0;
    e_data = 0;
    if (m_mode == 1) begin
      if (op == 1 || op == 3) e_wa = 1;
      if (op == 2 || op == 4) e_wb = 1;
      if (op == 1 || op == 2) e_data = imm;
      if (op == 3 || op == 4) e_data = int'(ar);
    end
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("wen_a", 32'(wen_a), 32'(e_wa));
    chk("wen_b", 32'(wen_b), 32'(e_wb));
    chk("data", 32'(data), 32'(e_data));
    chk("halted", 32'(halted), (m_mode == 2) ? 32'd1 : 32'd0);
    chk("icount", 32'(icount), 32'(m_cnt));
    chk("state", 32'(state_dbg), 32'(mode_to_state(m_mode)));
    if (wen_a && wen_b) ever_both++;
    @(posedge clk);
    if (m_mode == 0) begin
      if (run_v) m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_cnt < 255) m_cnt++;
      if (op == 15) m_mode = 2;
      else if (op == 5) m_pc = imm % 16;
      else if (op == 6 && az) m_pc = imm % 16;
      else m_pc = (m_pc + 1) % 16;
    end
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for clk.
  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    #1;
    m_mode = 0;
    m_pc = 0;
    m_cnt = 0;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_wen", {30'd0, wen_a, wen_b}, 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_icount", 32'(icount), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    int guard;
    fill_rom(8'h00);
    @(negedge clk);
    do_reset();

    // Idle with run low: nothing moves
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h0);
    chk("idle_pc", 32'(pc), 32'd0);

    // LDA 3, LDB 5, ADDA, HLT
    rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'h30; rom[3] = 8'hF0;
    cycle(1'b1, 1'b0, 4'h0);
    guard = 0;
    while (m_mode != 2 && guard < 20) begin
      cycle(1'b0, 1'b0, 4'h8);
      guard++;
    end
    chk("prog_timeout", 32'(guard < 20), 32'd1);
    #1;
    chk("prog_halted", 32'(halted), 32'd1);
    chk("prog_pc", 32'(pc), 32'd3);
    chk("prog_icount", 32'(icount), 32'd4);
    // run is ignored while halted
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'h0);
    chk("halt_sticky", 32'(halted), 32'd1);

    // JMP 9, JZ not taken, JZ taken
    fill_rom(8'h00);
    rom[0] = 8'h59; rom[9] = 8'h62; rom[10] = 8'h62;
    do_reset();
    cycle(1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);
    chk("jmp_pc", 32'(pc), 32'd9);
    cycle(1'b0, 1'b0, 4'h0);
    chk("jz_nt_pc", 32'(pc), 32'd10);
    cycle(1'b0, 1'b1, 4'h0);
    chk("jz_t_pc", 32'(pc), 32'd2);

    // 16 NOPs wrap the pc
    fill_rom(8'h00);
    do_reset();
    cycle(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_icount", 32'(icount), 32'd16);

    // Mid-program reset at pc=6, then restart
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 4'h0);
    chk("pre_rst_pc", 32'(pc), 32'd6);
    do_reset();
    cycle(1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0);
    chk("restart_pc", 32'(pc), 32'd1);

    // Undefined opcode behaves as NOP
    fill_rom(8'h7A);
    do_reset();
    cycle(1'b1, 1'b0, 4'h3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'h3);
    chk("undef_pc", 32'(pc), 32'd3);

    // Random programs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 16; i++) begin
        int sel;
        sel = int'($urandom_range(0, 19));
        if (sel < 8) rom[i] = 8'($urandom_range(0, 4) * 16 + $urandom_range(0, 15));
        else if (sel < 12) rom[i] = 8'($urandom_range(5, 6) * 16 + $urandom_range(0, 15));
        else if (sel < 19) rom[i] = 8'($urandom_range(7, 14) * 16 + $urandom_range(0, 15));
        else rom[i] = 8'hF0 | 8'($urandom_range(0, 15));
      end
      do_reset();
      for (int i = 0; i < 50; i++)
        cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // Saturation after 300 NOPs
    fill_rom(8'h00);
    do_reset();
    cycle(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 4'h0);
    chk("sat_icount", 32'(icount), 32'd255);
    chk("never_both_wen", 32'(ever_both), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
